// File: rtl/axi_mux_pkg.sv
// Shared AXI defines and channel typedefs used by the N-to-1 AXI multiplexer.
// The ID width and master limit sit beside the channel structs they size.
`ifndef AXI_ID_W
`define AXI_ID_W 4
`endif
`ifndef AXI_MUX_MAX
`define AXI_MUX_MAX 4
`endif

package axi_mux_pkg;

  localparam int AXI_ID_W    = `AXI_ID_W;
  localparam int AXI_MUX_MAX = `AXI_MUX_MAX;
  localparam int AXI_ADDR_W  = 32;
  localparam int AXI_DATA_W  = 32;

  typedef struct packed {
    logic                  valid;
    logic [AXI_ID_W-1:0]   id;
    logic [AXI_ADDR_W-1:0] addr;
    logic [7:0]            len;
    logic [2:0]            size;
    logic [1:0]            burst;
    logic                  lock;
    logic [3:0]            cache;
    logic [2:0]            prot;
    logic [3:0]            qos;
    logic [3:0]            region;
    logic                  user;
  } axi_ax_t;

  typedef struct packed {
    logic                    valid;
    logic [AXI_DATA_W-1:0]   data;
    logic [AXI_DATA_W/8-1:0] strb;
    logic                    last;
    logic                    user;
  } axi_w_t;

  typedef struct packed {
    logic                  valid;
    logic [AXI_ID_W-1:0]   id;
    logic [AXI_DATA_W-1:0] data;
    logic [1:0]            resp;
    logic                  last;
    logic                  user;
  } axi_r_t;

  typedef struct packed {
    logic                valid;
    logic [AXI_ID_W-1:0] id;
    logic [1:0]          resp;
    logic                user;
  } axi_b_t;

  typedef struct packed {
    logic ready;
  } axi_ready_t;

endpackage

// File: rtl/axi_mux_if.sv
// AXI4 port bundle: m-prefixed channels are driven by the master, s-prefixed by the slave.
interface AxiIO;
  import axi_mux_pkg::*;

  axi_ax_t    mar;
  axi_ready_t sar;
  axi_ax_t    maw;
  axi_ready_t saw;
  axi_w_t     mw;
  axi_ready_t sw;
  axi_r_t     sr;
  axi_ready_t mr;
  axi_b_t     sb;
  axi_ready_t mb;

  modport master (output mar, maw, mw, mr, mb, input sar, saw, sw, sr, sb);
  modport slave  (input mar, maw, mw, mr, mb, output sar, saw, sw, sr, sb);
endinterface

// File: rtl/axi_rr_arb.sv
// Round-robin arbiter with a grant lock that freezes the winner while the
// downstream request is stalled; the pointer moves past the winner on handshake.
module axi_rr_arb #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic          lock,
  input  logic          done,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          grant_vld
);

  logic [IW-1:0] ptr_q;
  logic [IW-1:0] lock_idx_q;
  logic          lock_q;
  logic [IW-1:0] pick_idx;
  logic          pick_vld;
  int            cand;

  // Scan from the farthest offset down so the request closest to ptr wins last.
  always_comb begin
    pick_idx = '0;
    pick_vld = 1'b0;
    cand     = 0;
    for (int k = N - 1; k >= 0; k--) begin
      cand = (int'(ptr_q) + k) % N;
      if (req[IW'(cand)]) begin
        pick_idx = IW'(cand);
        pick_vld = 1'b1;
      end
    end
  end

  assign grant_idx = lock_q ? lock_idx_q : pick_idx;
  assign grant_vld = lock_q | pick_vld;

  always_comb begin
    grant = '0;
    if (grant_vld) grant[grant_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr_q      <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else if (done) begin
      ptr_q  <= (grant_idx == IW'(N - 1)) ? '0 : grant_idx + IW'(1);
      lock_q <= 1'b0;
    end else if (lock && !lock_q) begin
      lock_q     <= 1'b1;
      lock_idx_q <= grant_idx;
    end
  end

endmodule

// File: rtl/axi_mux.sv
// N-to-1 AXI4 multiplexer: round-robin AR/AW, W steered by AW grant order,
// R/B routed back by the master index carried in the top ID bits.
module axi_mux
  import axi_mux_pkg::*;
#(
  parameter int MASTER_NUM   = 2,
  parameter int W_FIFO_DEPTH = 4
) (
  input logic  clk,
  input logic  rst,
  AxiIO.slave  m [MASTER_NUM],
  AxiIO.master s
);

  localparam int IDX_W = $clog2(MASTER_NUM);
  localparam int LOW_W = AXI_ID_W - IDX_W;
  localparam int PTR_W = $clog2(W_FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  axi_ax_t ar_in [MASTER_NUM];
  axi_ax_t aw_in [MASTER_NUM];
  axi_w_t  w_in  [MASTER_NUM];

  logic [MASTER_NUM-1:0] ar_req, aw_valid, aw_req, ar_grant, aw_grant;
  logic [MASTER_NUM-1:0] mr_ready, mb_ready;
  logic [IDX_W-1:0]      ar_idx, aw_idx;
  logic                  ar_gvld, aw_gvld;
  axi_ax_t               ar_out, aw_out;
  axi_w_t                w_out;

  logic [IDX_W-1:0] fifo_mem [W_FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] fifo_cnt;
  logic [IDX_W-1:0] fifo_head;
  logic             fifo_full, fifo_empty, aw_block, aw_push, w_pop;

  logic [IDX_W-1:0]    r_k, b_k;
  logic [AXI_ID_W-1:0] r_id, b_id;
  logic                r_hit, b_hit;

  for (genvar i = 0; i < MASTER_NUM; i++) begin : g_m
    assign ar_in[i]    = m[i].mar;
    assign aw_in[i]    = m[i].maw;
    assign w_in[i]     = m[i].mw;
    assign ar_req[i]   = m[i].mar.valid;
    assign aw_valid[i] = m[i].maw.valid;
    assign mr_ready[i] = m[i].mr.ready;
    assign mb_ready[i] = m[i].mb.ready;

    assign m[i].sar = '{ready: rst & s.sar.ready & ar_grant[i]};
    assign m[i].saw = '{ready: rst & s.saw.ready & aw_grant[i] & ~aw_block};
    assign m[i].sw  = '{ready: rst & ~fifo_empty & (fifo_head == IDX_W'(i)) & s.sw.ready};

    assign m[i].sr = '{valid: rst & s.sr.valid & (r_k == IDX_W'(i)),
                       id: r_id, data: s.sr.data, resp: s.sr.resp,
                       last: s.sr.last, user: s.sr.user};
    assign m[i].sb = '{valid: rst & s.sb.valid & (b_k == IDX_W'(i)),
                       id: b_id, resp: s.sb.resp, user: s.sb.user};
  end

  axi_rr_arb #(.N(MASTER_NUM), .IW(IDX_W)) u_ar_arb (
    .clk(clk), .rst(rst), .req(ar_req),
    .lock(ar_out.valid & ~s.sar.ready), .done(ar_out.valid & s.sar.ready),
    .grant(ar_grant), .grant_idx(ar_idx), .grant_vld(ar_gvld)
  );

  axi_rr_arb #(.N(MASTER_NUM), .IW(IDX_W)) u_aw_arb (
    .clk(clk), .rst(rst), .req(aw_req),
    .lock(aw_out.valid & ~s.saw.ready), .done(aw_push),
    .grant(aw_grant), .grant_idx(aw_idx), .grant_vld(aw_gvld)
  );

  always_comb begin
    ar_out       = ar_in[ar_idx];
    ar_out.id    = {ar_idx, ar_in[ar_idx].id[LOW_W-1:0]};
    ar_out.valid = rst & ar_gvld & ar_in[ar_idx].valid;
  end
  assign s.mar = ar_out;

  // A full order FIFO still accepts an AW in the cycle its head retires.
  assign fifo_full  = (fifo_cnt == CNT_W'(W_FIFO_DEPTH));
  assign fifo_empty = (fifo_cnt == '0);
  assign fifo_head  = fifo_mem[rd_ptr];
  assign aw_block   = fifo_full & ~w_pop;
  assign aw_req     = aw_valid & {MASTER_NUM{~aw_block}};
  assign aw_push    = aw_out.valid & s.saw.ready;

  always_comb begin
    aw_out       = aw_in[aw_idx];
    aw_out.id    = {aw_idx, aw_in[aw_idx].id[LOW_W-1:0]};
    aw_out.valid = rst & ~aw_block & aw_gvld & aw_in[aw_idx].valid;
  end
  assign s.maw = aw_out;

  always_comb begin
    w_out       = w_in[fifo_head];
    w_out.valid = rst & ~fifo_empty & w_in[fifo_head].valid;
  end
  assign s.mw  = w_out;
  assign w_pop = w_out.valid & s.sw.ready & w_out.last;

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (aw_push) begin
        fifo_mem[wr_ptr] <= aw_idx;
        wr_ptr           <= wr_ptr + PTR_W'(1);
      end
      if (w_pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({aw_push, w_pop})
        2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // Responses whose prefix names no master are swallowed so the bus never stalls.
  assign r_k   = s.sr.id[AXI_ID_W-1 -: IDX_W];
  assign b_k   = s.sb.id[AXI_ID_W-1 -: IDX_W];
  assign r_id  = {{IDX_W{1'b0}}, s.sr.id[LOW_W-1:0]};
  assign b_id  = {{IDX_W{1'b0}}, s.sb.id[LOW_W-1:0]};
  assign r_hit = (int'(r_k) < MASTER_NUM);
  assign b_hit = (int'(b_k) < MASTER_NUM);
  assign s.mr  = '{ready: rst & (r_hit ? mr_ready[r_k] : 1'b1)};
  assign s.mb  = '{ready: rst & (b_hit ? mb_ready[b_k] : 1'b1)};

endmodule

// File: tb/tb_axi_mux.sv
// Directed bench for axi_mux with two masters and a two-deep W-order FIFO.
module tb_axi_mux;
  import axi_mux_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   errors;
  int   checks;

  AxiIO m_if [2] ();
  AxiIO s_if ();

  axi_mux #(.MASTER_NUM(2), .W_FIFO_DEPTH(2)) dut (
    .clk(clk), .rst(rst), .m(m_if), .s(s_if)
  );

  always #5 clk = ~clk;

  task automatic applyStimulus();
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst    = 1'b0;
    m_if[0].mar = '0; m_if[0].maw = '0; m_if[0].mw = '0; m_if[0].mr = '0; m_if[0].mb = '0;
    m_if[1].mar = '0; m_if[1].maw = '0; m_if[1].mw = '0; m_if[1].mr = '0; m_if[1].mb = '0;
    s_if.sar = '0; s_if.saw = '0; s_if.sw = '0; s_if.sr = '0; s_if.sb = '0;
    repeat (2) applyStimulus();

    // Outputs held quiet while in reset even with live inputs
    m_if[0].mar.valid = 1'b1;
    s_if.sar.ready    = 1'b1;
    s_if.sr.valid     = 1'b1;
    m_if[0].mr.ready  = 1'b1;
    #1;
    checkOutput("rst_mar_valid", 64'(s_if.mar.valid), 64'd0);
    checkOutput("rst_sar_ready", 64'(m_if[0].sar.ready), 64'd0);
    checkOutput("rst_sr_valid", 64'(m_if[0].sr.valid), 64'd0);
    checkOutput("rst_mr_ready", 64'(s_if.mr.ready), 64'd0);
    s_if.sr.valid    = 1'b0;
    m_if[0].mr.ready = 1'b0;

    // AR round robin: 0x3 from m0, 0xD from m1, alternating
    applyStimulus();
    rst = 1'b1;
    m_if[0].mar.valid = 1'b1; m_if[0].mar.addr = 32'h100; m_if[0].mar.id = 4'h3;
    m_if[1].mar.valid = 1'b1; m_if[1].mar.addr = 32'h200; m_if[1].mar.id = 4'h5;
    for (int n = 0; n < 4; n++) begin
      if (n != 0) applyStimulus();
      #1;
      checkOutput("rr_id", 64'(s_if.mar.id), (n % 2 == 1) ? 64'hD : 64'h3);
      checkOutput("rr_m1_ready", 64'(m_if[1].sar.ready), 64'(n % 2));
    end

    // Lock: m1 stalls five cycles, m0 arrives and waits
    applyStimulus();
    m_if[0].mar.valid = 1'b0;
    s_if.sar.ready    = 1'b0;
    #1;
    checkOutput("lock_first_id", 64'(s_if.mar.id), 64'hD);
    for (int n = 1; n < 5; n++) begin
      applyStimulus();
      m_if[0].mar.valid = 1'b1;
      #1;
      checkOutput("lock_addr", 64'(s_if.mar.addr), 64'h200);
      checkOutput("lock_id", 64'(s_if.mar.id), 64'hD);
      checkOutput("lock_m0_ready", 64'(m_if[0].sar.ready), 64'd0);
    end
    applyStimulus();
    s_if.sar.ready = 1'b1;
    #1;
    checkOutput("lock_release_m1", 64'(m_if[1].sar.ready), 64'd1);
    applyStimulus();
    #1;
    checkOutput("lock_next_id", 64'(s_if.mar.id), 64'h3);
    checkOutput("lock_next_m0", 64'(m_if[0].sar.ready), 64'd1);

    // Write ordering: m1 burst of 4, then m0 single beat
    applyStimulus();
    m_if[0].mar.valid = 1'b0; m_if[1].mar.valid = 1'b0; s_if.sar.ready = 1'b0;
    m_if[1].maw.valid = 1'b1; m_if[1].maw.addr = 32'h300; m_if[1].maw.len = 8'd3; m_if[1].maw.id = 4'h2;
    s_if.saw.ready = 1'b1;
    m_if[1].mw.valid = 1'b1; m_if[1].mw.data = 32'h1000; m_if[1].mw.last = 1'b0;
    s_if.sw.ready = 1'b1;
    #1;
    checkOutput("wo_aw1_id", 64'(s_if.maw.id), 64'hA);
    checkOutput("wo_aw1_ready", 64'(m_if[1].saw.ready), 64'd1);
    checkOutput("wo_w_same_cycle", 64'(s_if.mw.valid), 64'd0);
    applyStimulus();
    m_if[1].maw.valid = 1'b0;
    m_if[0].maw.valid = 1'b1; m_if[0].maw.addr = 32'h400; m_if[0].maw.len = 8'd0; m_if[0].maw.id = 4'h1;
    m_if[0].mw.valid = 1'b1; m_if[0].mw.data = 32'hA0; m_if[0].mw.last = 1'b1;
    #1;
    checkOutput("wo_aw2_id", 64'(s_if.maw.id), 64'h1);
    for (int j = 0; j < 4; j++) begin
      if (j != 0) begin
        applyStimulus();
        m_if[0].maw.valid = 1'b0;
      end
      m_if[1].mw.data = 32'h1000 + 32'(j);
      m_if[1].mw.last = (j == 3);
      #1;
      checkOutput("wo_m1_data", 64'(s_if.mw.data), 64'(32'h1000 + 32'(j)));
      checkOutput("wo_m1_last", 64'(s_if.mw.last), 64'(j == 3));
      checkOutput("wo_m0_blocked", 64'(m_if[0].sw.ready), 64'd0);
    end
    applyStimulus();
    m_if[1].mw.valid = 1'b0;
    #1;
    checkOutput("wo_m0_data", 64'(s_if.mw.data), 64'hA0);
    checkOutput("wo_m0_ready", 64'(m_if[0].sw.ready), 64'd1);
    applyStimulus();
    #1;
    checkOutput("wo_fifo_empty", 64'(s_if.mw.valid), 64'd0);

    // FIFO full: third AW waits for the head's last beat
    applyStimulus();
    m_if[0].mw.valid = 1'b0;
    m_if[0].maw.valid = 1'b1; m_if[0].maw.addr = 32'h500;
    #1;
    checkOutput("ff_aw1_valid", 64'(s_if.maw.valid), 64'd1);
    applyStimulus();
    m_if[0].maw.addr = 32'h504;
    #1;
    checkOutput("ff_aw2_valid", 64'(s_if.maw.valid), 64'd1);
    for (int n = 0; n < 2; n++) begin
      applyStimulus();
      m_if[0].maw.addr = 32'h508;
      #1;
      checkOutput("ff_blocked_valid", 64'(s_if.maw.valid), 64'd0);
      checkOutput("ff_blocked_ready", 64'(m_if[0].saw.ready), 64'd0);
    end
    applyStimulus();
    m_if[0].mw.valid = 1'b1; m_if[0].mw.data = 32'hB0; m_if[0].mw.last = 1'b1;
    #1;
    checkOutput("ff_pushpop_valid", 64'(s_if.maw.valid), 64'd1);
    checkOutput("ff_pushpop_addr", 64'(s_if.maw.addr), 64'h508);
    checkOutput("ff_pushpop_w", 64'(s_if.mw.valid), 64'd1);
    applyStimulus();
    m_if[0].maw.valid = 1'b0;
    #1;
    checkOutput("ff_drain1", 64'(s_if.mw.valid), 64'd1);
    applyStimulus();
    #1;
    checkOutput("ff_drain2", 64'(s_if.mw.valid), 64'd1);
    applyStimulus();
    #1;
    checkOutput("ff_empty", 64'(s_if.mw.valid), 64'd0);

    // Response routing by ID prefix, R and B in parallel
    applyStimulus();
    m_if[0].mw.valid = 1'b0;
    s_if.sr.valid = 1'b1; s_if.sr.id = 4'hA; s_if.sr.data = 32'hDEAD;
    m_if[1].mr.ready = 1'b1; m_if[0].mr.ready = 1'b0;
    s_if.sb.valid = 1'b1; s_if.sb.id = 4'h9;
    m_if[1].mb.ready = 1'b0; m_if[0].mb.ready = 1'b1;
    #1;
    checkOutput("r_m1_valid", 64'(m_if[1].sr.valid), 64'd1);
    checkOutput("r_m1_id", 64'(m_if[1].sr.id), 64'h2);
    checkOutput("r_m1_data", 64'(m_if[1].sr.data), 64'hDEAD);
    checkOutput("r_m0_valid", 64'(m_if[0].sr.valid), 64'd0);
    checkOutput("r_ready", 64'(s_if.mr.ready), 64'd1);
    checkOutput("b_m1_valid", 64'(m_if[1].sb.valid), 64'd1);
    checkOutput("b_m1_id", 64'(m_if[1].sb.id), 64'h1);
    checkOutput("b_m0_valid", 64'(m_if[0].sb.valid), 64'd0);
    checkOutput("b_ready", 64'(s_if.mb.ready), 64'd0);
    applyStimulus();
    m_if[1].mr.ready = 1'b0;
    #1;
    checkOutput("r_ready_follow", 64'(s_if.mr.ready), 64'd0);
    applyStimulus();
    s_if.sr.id = 4'h3; m_if[0].mr.ready = 1'b1;
    #1;
    checkOutput("r_m0_valid2", 64'(m_if[0].sr.valid), 64'd1);
    checkOutput("r_m0_id2", 64'(m_if[0].sr.id), 64'h3);
    checkOutput("r_m1_valid2", 64'(m_if[1].sr.valid), 64'd0);
    checkOutput("r_ready2", 64'(s_if.mr.ready), 64'd1);

    // Reset mid-flight: lock held on m1, one AW queued
    applyStimulus();
    s_if.sr.valid = 1'b0; s_if.sb.valid = 1'b0;
    m_if[0].mar.valid = 1'b1; m_if[1].mar.valid = 1'b1; s_if.sar.ready = 1'b0;
    m_if[0].maw.valid = 1'b1; m_if[0].maw.addr = 32'h600;
    m_if[0].mw.valid = 1'b1; m_if[0].mw.data = 32'hC0; m_if[0].mw.last = 1'b0;
    #1;
    checkOutput("rs_pre_id", 64'(s_if.mar.id), 64'hD);
    checkOutput("rs_pre_aw", 64'(s_if.maw.valid), 64'd1);
    applyStimulus();
    rst = 1'b0;
    m_if[0].maw.valid = 1'b0;
    s_if.sar.ready = 1'b1;
    s_if.sr.valid = 1'b1;
    #1;
    checkOutput("rs_mar_valid", 64'(s_if.mar.valid), 64'd0);
    checkOutput("rs_m1_ready", 64'(m_if[1].sar.ready), 64'd0);
    checkOutput("rs_mw_valid", 64'(s_if.mw.valid), 64'd0);
    checkOutput("rs_sw_ready", 64'(m_if[0].sw.ready), 64'd0);
    checkOutput("rs_sr_valid", 64'(m_if[0].sr.valid), 64'd0);
    checkOutput("rs_mr_ready", 64'(s_if.mr.ready), 64'd0);
    applyStimulus();
    rst = 1'b1;
    s_if.sr.valid = 1'b0;
    #1;
    checkOutput("rs_after_id", 64'(s_if.mar.id), 64'h3);
    checkOutput("rs_after_m0", 64'(m_if[0].sar.ready), 64'd1);
    checkOutput("rs_after_fifo", 64'(s_if.mw.valid), 64'd0);

    applyStimulus();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/axi_mux.md
# axi_mux

N-to-1 AXI4 multiplexer joining up to four upstream AXI masters (ICache, DCache, PTW, debug) onto one downstream `AxiIO` port toward the L2/memory bus. AR and AW use independent round-robin arbitration with a grant lock. W beats follow AW grant order through a small order FIFO. R and B responses return to their master by ID prefix bits inserted on the request path.

## Interface
- `MASTER_NUM`, default 2: number of upstream masters; legal range 2..4.
- `W_FIFO_DEPTH`, default 4: depth of the W-order FIFO (power of two, ≥2).
- Derived `IDX_W = $clog2(MASTER_NUM)`. Each master uses only ID bits `[3-IDX_W:0]`; its upper `IDX_W` ID bits must be 0.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-low.
- `m[MASTER_NUM]` `AxiIO.slave`: upstream ports; this block is their slave.
- `s` `AxiIO.master`: downstream port.

## Operation
- **AR path:**
  - When not locked, the round-robin arbiter picks among `m[i].mar.valid`, starting at the index after the last winner.
  - The winner's `mar` is forwarded to `s.mar`, with `id = {i[IDX_W-1:0], m[i].mar.id[3-IDX_W:0]}`.
  - `m[i].sar.ready = s.sar.ready & grant[i]`. All other masters see ready 0.
  - If `s.mar.valid & !s.sar.ready`, the grant locks, and stays locked until the handshake completes. This keeps the downstream request stable.
  - On the handshake, the pointer advances to winner+1.
- **AW path:**
  - Same arbitration as AR, with an independent lock and pointer.
  - Additional grant condition: the W-order FIFO is not full. While it is full, `s.maw.valid = 0`.
  - An AW handshake pushes the winner index into the FIFO.
- **W path:**
  - With the FIFO non-empty and head = k: `s.mw = m[k].mw` and `m[k].sw.ready = s.sw.ready`.
  - A beat with `last` accepted pops the FIFO.
  - With the FIFO empty: `s.mw.valid = 0` and all `sw.ready = 0`.
  - A push and a pop in the same cycle keep the count unchanged; this is legal when full.
- **R path:**
  - `k = s.sr.id[3:4-IDX_W]`. Forward `s.sr` to `m[k].sr` with the upper ID bits cleared.
  - `valid` goes only to `m[k]`; `s.mr.ready = m[k].mr.ready`.
  - An ID prefix ≥ `MASTER_NUM` is dropped with `s.mr.ready = 1`.
- **B path:** same as R, using `sb`/`mb`.
- **Unused fields:** `qos`, `region`, `user`, `lock`, `cache`, `prot` pass through unchanged.

## Timing
- Request and response paths are combinational pass-through: zero added latency.
- State (arbiter pointers, locks, FIFO) updates on the `clk` rising edge.
- **Reset** (`rst=0` at a clock edge):
  - Pointers reset to 0, locks clear, FIFO empties.
  - While `rst=0`, every `valid` and `ready` output is forced to 0.
  - Reset mid-burst discards the in-flight order; the downstream side is reset in the same domain.
- **Lock:** once a downstream valid is asserted, the granted master and the forwarded fields hold every cycle until ready. A higher-priority request arriving meanwhile does not pre-empt.
- **Same-cycle events:** AR and AW may be granted to different masters in the same cycle. W beats for the head entry may arrive in the same cycle as their AW handshake; they are forwarded only from the next cycle, when the FIFO head is valid. R and B to different masters proceed in parallel.
- **Fairness:** with `MASTER_NUM` masters continuously requesting, each is granted once every `MASTER_NUM` handshakes.

## Structure
- Add `` `AXI_ID_W `` (4) and `` `AXI_MUX_MAX `` (4) to the shared AXI defines header, beside the channel typedefs.
- Sub-module `axi_rr_arb`: parametrised round-robin arbiter with a lock input. It outputs a one-hot grant and its index, and is instantiated for AR and AW.
- W-order FIFO is inline: `W_FIFO_DEPTH` × `IDX_W` bits, with pointer wrap plus a count.

## Test plan
- **AR round-robin:** masters 0 and 1 both request continuously, `sar.ready=1` → downstream IDs alternate `0x0_`/`0x8_` (IDX_W=1), starting with master 0 after reset.
- **Lock:** master 1 granted, `sar.ready` held 0 for 5 cycles, master 0 then raises valid → `s.mar` stays master 1's addr/ID for all 5 cycles; master 0 is granted on the next cycle.
- **Write ordering:** AW from m1 (len=3) then m0 (len=0) → 4 beats of m1, then 1 beat of m0 on `s.mw`; the FIFO is empty afterward.
- **FIFO full:** `W_FIFO_DEPTH=2`, three AWs with W withheld → the third AW is not forwarded until m-first's `last` beat, which lands in the same cycle as the push.
- **Response routing:** `s.sr.id=0xA`, MASTER_NUM=2 → `m[1].sr.valid=1` with id `0x2`; `m[0].sr.valid=0`; `s.mr.ready` follows `m[1].mr.ready`.
- **Reset:** `rst=0` mid-burst with valids asserted → all valid/ready outputs are 0 that cycle; after release, the pointers are 0 and the first grant goes to master 0.
